// File: rtl/wheel_animator.sv
// ---------------------------------------------------------------------------
// wheel_animator
//
// Turns a per-channel position stream into a rolling-wheel sprite index.
// Each channel is sampled once per video frame (tick). The distance moved
// since the previous sample is accumulated, and every STEP units of travel
// advance the sprite frame by one. The frame steps backwards while the
// position decreases. A channel that has not moved for IDLE_TICKS samples
// reports itself as no longer moving. Channels are fully independent.
//
// Ports
//   clk      : the only clock
//   reset    : synchronous, active-high; clears every channel
//   tick     : one-clk sample strobe, once per video frame
//   position : CHANNELS x POS_W unsigned positions, channel i at [i*POS_W +: POS_W]
//   frame    : CHANNELS x FRAME_W sprite indices, channel i at [i*FRAME_W +: FRAME_W]
//   moving   : per channel, wheel considered in motion
//   reverse  : per channel, direction of last nonzero motion (1 = decreasing)
//   mov      : per channel, legacy toggle that flips on every sample with motion
// ---------------------------------------------------------------------------
module wheel_animator #(
   parameter int CHANNELS   = 2,
   parameter int POS_W      = 32,
   parameter int FRAMES     = 4,
   parameter int FRAME_W    = 2,
   parameter int STEP       = 16,
   parameter int IDLE_TICKS = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        tick,
   input  logic [CHANNELS*POS_W-1:0]   position,
   output logic [CHANNELS*FRAME_W-1:0] frame,
   output logic [CHANNELS-1:0]         moving,
   output logic [CHANNELS-1:0]         reverse,
   output logic [CHANNELS-1:0]         mov
);

   // The accumulator only ever holds values below STEP, so clog2(STEP)+1 bits
   // leave headroom; the sum of accumulator and capped magnitude gets one more.
   localparam int ACC_W  = $clog2(STEP) + 1;
   localparam int IDLE_W = $clog2(IDLE_TICKS + 1);

   localparam logic [POS_W-1:0]   STEP_POS   = POS_W'(STEP);
   localparam logic [ACC_W-1:0]   STEP_ACC   = ACC_W'(STEP);
   localparam logic [ACC_W:0]     STEP_SUM   = (ACC_W+1)'(STEP);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);
   localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_TICKS);

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

      logic [POS_W-1:0]   pos_in;
      logic [POS_W-1:0]   pos_mem;
      logic [POS_W-1:0]   mag;
      logic [ACC_W-1:0]   magc;
      logic [ACC_W-1:0]   acc;
      logic [ACC_W-1:0]   acc_base;
      logic [ACC_W-1:0]   acc_next;
      logic [ACC_W:0]     sum;
      logic [IDLE_W-1:0]  idle_cnt;
      logic [IDLE_W-1:0]  idle_inc;
      logic [FRAME_W-1:0] frame_q;
      logic [FRAME_W-1:0] frame_step;
      logic               primed;
      logic               dir;
      logic               advance;
      logic               moving_q;
      logic               reverse_q;
      logic               mov_q;

      assign pos_in = position[ch*POS_W +: POS_W];

      // Work out what a primed sample would do to this channel: how far and in
      // which direction the wheel rolled, how much travel carries over, whether
      // the sprite steps, and what the idle counter becomes if nothing moved.
      // The magnitude is a plain unsigned difference, so a position that wraps
      // around the top of its range reads as one huge jump, which the cap to
      // STEP then limits to a single frame advance.
      always_comb begin
         dir        = 1'b0;
         mag        = '0;
         magc       = '0;
         acc_base   = '0;
         sum        = '0;
         advance    = 1'b0;
         acc_next   = '0;
         frame_step = frame_q;
         idle_inc   = idle_cnt;

         dir = (pos_in < pos_mem);
         mag = dir ? (pos_mem - pos_in) : (pos_in - pos_mem);
         magc = (mag > STEP_POS) ? STEP_ACC : mag[ACC_W-1:0];

         // Travel gathered while rolling the other way must not count towards
         // the first frame step in the new direction.
         acc_base = (dir != reverse_q) ? '0 : acc;
         sum      = {1'b0, acc_base} + {1'b0, magc};
         advance  = (sum >= STEP_SUM);
         acc_next = advance ? ACC_W'(sum - STEP_SUM) : sum[ACC_W-1:0];

         if (dir) begin
            frame_step = (frame_q == '0) ? FRAME_LAST : frame_q - 1'b1;
         end else begin
            frame_step = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
         end

         idle_inc = (idle_cnt == IDLE_MAX) ? IDLE_MAX : idle_cnt + 1'b1;
      end

      // Channel state register. Nothing changes between samples. The first
      // sample after reset only records the position so that there is a
      // reference to measure the next one against. After that every sample
      // is either still (count towards idle) or motion (accumulate travel,
      // maybe step the sprite, flip the legacy toggle).
      always_ff @(posedge clk) begin
         if (reset) begin
            pos_mem   <= '0;
            acc       <= '0;
            idle_cnt  <= '0;
            primed    <= 1'b0;
            frame_q   <= '0;
            moving_q  <= 1'b0;
            reverse_q <= 1'b0;
            mov_q     <= 1'b0;
         end else if (tick) begin
            pos_mem <= pos_in;
            if (!primed) begin
               primed <= 1'b1;
            end else if (mag == '0) begin
               idle_cnt <= idle_inc;
               if (idle_inc == IDLE_MAX) begin
                  moving_q <= 1'b0;
               end
            end else begin
               idle_cnt  <= '0;
               moving_q  <= 1'b1;
               mov_q     <= ~mov_q;
               reverse_q <= dir;
               acc       <= acc_next;
               if (advance) begin
                  frame_q <= frame_step;
               end
            end
         end
      end

      assign frame[ch*FRAME_W +: FRAME_W] = frame_q;
      assign moving[ch]                   = moving_q;
      assign reverse[ch]                  = reverse_q;
      assign mov[ch]                      = mov_q;

   end

endmodule

// File: tb/tb_wheel_animator.sv
// ---------------------------------------------------------------------------
// tb_wheel_animator
//
// Directed bench for wheel_animator with default parameters. Channel 0 is
// driven through priming, forward rolling, a capped jump, reversal with
// frame wraparound, idling, sample gating and a reset in the middle of
// motion. Channel 1 stays parked at a constant position the whole time, so
// its outputs must remain zero. Expected values are worked out by hand from
// the position sequence applied to channel 0.
// ---------------------------------------------------------------------------
module tb_wheel_animator;

   logic        clk;
   logic        reset;
   logic        tick;
   logic [63:0] position;
   logic [3:0]  frame;
   logic [1:0]  moving;
   logic [1:0]  reverse;
   logic [1:0]  mov;

   int errors;
   int checks;

   // Observed per-channel bundle: {frame, moving, reverse, mov}
   logic [4:0] ch0_obs;
   logic [4:0] ch1_obs;
   logic [4:0] exp0;
   logic       exp_mov;

   assign ch0_obs = {frame[1:0], moving[0], reverse[0], mov[0]};
   assign ch1_obs = {frame[3:2], moving[1], reverse[1], mov[1]};

   wheel_animator dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .position (position),
      .frame    (frame),
      .moving   (moving),
      .reverse  (reverse),
      .mov      (mov)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One sample of channel 0 at position p0: tick is high across exactly one
   // rising edge, and the caller looks at the outputs on the following
   // falling edge.
   task automatic applyStimulus(input logic [31:0] p0);
      @(negedge clk);
      position[31:0] = p0;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick  = 1'b0;
      position = {32'd500, 32'd0};
      repeat (2) @(negedge clk);
      checks++;
      if (ch0_obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL reset_ch0 got=%b want=%b", ch0_obs, 5'b00000);
      end
      checks++;
      if (ch1_obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL reset_ch1 got=%b want=%b", ch1_obs, 5'b00000);
      end
      reset = 1'b0;
   endtask

   task automatic test_priming();
      applyStimulus(32'd1000);
      checks++;
      if (ch0_obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL prime_first got=%b want=%b", ch0_obs, 5'b00000);
      end
      applyStimulus(32'd1000);
      checks++;
      if (ch0_obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL prime_still got=%b want=%b", ch0_obs, 5'b00000);
      end
   endtask

   // +8 per sample: travel 8,16,24,... so the sprite steps every second sample.
   task automatic test_forward();
      logic [1:0] fwd_frames [8];
      fwd_frames = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      exp_mov = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(32'(1000 + 8 * k));
         exp_mov = ~exp_mov;
         exp0 = {fwd_frames[k-1], 1'b1, 1'b0, exp_mov};
         checks++;
         if (ch0_obs !== exp0) begin
            errors++;
            $display("[TB] FAIL fwd_t%0d_ch0 got=%b want=%b", k, ch0_obs, exp0);
         end
         checks++;
         if (ch1_obs !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL fwd_t%0d_ch1 got=%b want=%b", k, ch1_obs, 5'b00000);
         end
      end
   endtask

   // A +100 jump is capped to one frame with nothing carried over: a further
   // +15 must not step, and the +1 after it must.
   task automatic test_cap();
      logic [31:0] cap_pos   [3];
      logic [1:0]  cap_frame [3];
      cap_pos   = '{32'd1164, 32'd1179, 32'd1180};
      cap_frame = '{2'd1, 2'd1, 2'd2};
      for (int k = 0; k < 3; k++) begin
         applyStimulus(cap_pos[k]);
         exp_mov = ~exp_mov;
         exp0 = {cap_frame[k], 1'b1, 1'b0, exp_mov};
         checks++;
         if (ch0_obs !== exp0) begin
            errors++;
            $display("[TB] FAIL cap_s%0d got=%b want=%b", k, ch0_obs, exp0);
         end
      end
   endtask

   // Bring channel 0 to frame 0 with 8 units carried forward, then roll back
   // 20 per sample. The carried 8 is discarded on reversal, so each -20
   // steps back exactly once: 0 -> 3 (wrap) -> 2.
   task automatic test_reverse_wrap();
      logic [31:0] rv_pos   [5];
      logic [1:0]  rv_frame [5];
      logic        rv_rev   [5];
      rv_pos   = '{32'd1196, 32'd1212, 32'd1220, 32'd1200, 32'd1180};
      rv_frame = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd2};
      rv_rev   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 5; k++) begin
         applyStimulus(rv_pos[k]);
         exp_mov = ~exp_mov;
         exp0 = {rv_frame[k], 1'b1, rv_rev[k], exp_mov};
         checks++;
         if (ch0_obs !== exp0) begin
            errors++;
            $display("[TB] FAIL rev_s%0d got=%b want=%b", k, ch0_obs, exp0);
         end
      end
   endtask

   task automatic test_idle();
      // Seven still samples keep moving high; the eighth drops it.
      repeat (7) applyStimulus(32'd1180);
      exp0 = {2'd2, 1'b1, 1'b1, exp_mov};
      checks++;
      if (ch0_obs !== exp0) begin
         errors++;
         $display("[TB] FAIL idle_7 got=%b want=%b", ch0_obs, exp0);
      end
      applyStimulus(32'd1180);
      exp0 = {2'd2, 1'b0, 1'b1, exp_mov};
      checks++;
      if (ch0_obs !== exp0) begin
         errors++;
         $display("[TB] FAIL idle_8 got=%b want=%b", ch0_obs, exp0);
      end

      // Restart motion forwards (+4, no step), then motion on the eighth sample.
      applyStimulus(32'd1184);
      exp_mov = ~exp_mov;
      exp0 = {2'd2, 1'b1, 1'b0, exp_mov};
      checks++;
      if (ch0_obs !== exp0) begin
         errors++;
         $display("[TB] FAIL idle_restart got=%b want=%b", ch0_obs, exp0);
      end
      repeat (7) applyStimulus(32'd1184);
      applyStimulus(32'd1188);
      exp_mov = ~exp_mov;
      exp0 = {2'd2, 1'b1, 1'b0, exp_mov};
      checks++;
      if (ch0_obs !== exp0) begin
         errors++;
         $display("[TB] FAIL idle_motion8 got=%b want=%b", ch0_obs, exp0);
      end

      // The counter restarted, so another seven still samples keep moving high.
      repeat (7) applyStimulus(32'd1188);
      checks++;
      if (ch0_obs !== exp0) begin
         errors++;
         $display("[TB] FAIL idle_recount7 got=%b want=%b", ch0_obs, exp0);
      end
      applyStimulus(32'd1188);
      exp0 = {2'd2, 1'b0, 1'b0, exp_mov};
      checks++;
      if (ch0_obs !== exp0) begin
         errors++;
         $display("[TB] FAIL idle_recount8 got=%b want=%b", ch0_obs, exp0);
      end
   endtask

   // Position changes without a tick are ignored, both for the outputs and
   // for the stored reference position.
   task automatic test_tick_gating();
      @(negedge clk);
      position[31:0] = 32'd5000;
      repeat (3) @(negedge clk);
      exp0 = {2'd2, 1'b0, 1'b0, exp_mov};
      checks++;
      if (ch0_obs !== exp0) begin
         errors++;
         $display("[TB] FAIL gate_hold got=%b want=%b", ch0_obs, exp0);
      end
      applyStimulus(32'd1188);
      checks++;
      if (ch0_obs !== exp0) begin
         errors++;
         $display("[TB] FAIL gate_still got=%b want=%b", ch0_obs, exp0);
      end
   endtask

   // Reset wins over a simultaneous motion sample. Afterwards 0xFFFFFFFF only
   // primes, and the following drop to 0 is one capped backwards step (0 -> 3).
   task automatic test_reset_mid();
      @(negedge clk);
      position[31:0] = 32'd1204;
      tick  = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      tick  = 1'b0;
      reset = 1'b0;
      checks++;
      if (ch0_obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL rstmid_ch0 got=%b want=%b", ch0_obs, 5'b00000);
      end
      checks++;
      if (ch1_obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL rstmid_ch1 got=%b want=%b", ch1_obs, 5'b00000);
      end
      applyStimulus(32'hFFFF_FFFF);
      checks++;
      if (ch0_obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL rstmid_prime got=%b want=%b", ch0_obs, 5'b00000);
      end
      applyStimulus(32'd0);
      exp0 = {2'd3, 1'b1, 1'b1, 1'b1};
      checks++;
      if (ch0_obs !== exp0) begin
         errors++;
         $display("[TB] FAIL wrap_pos got=%b want=%b", ch0_obs, exp0);
      end
      checks++;
      if (ch1_obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL end_ch1 got=%b want=%b", ch1_obs, 5'b00000);
      end
   endtask

   // Scenarios run in order; each one starts from the state the previous one
   // left behind.
   initial begin
      errors   = 0;
      checks   = 0;
      exp_mov  = 1'b0;
      reset    = 1'b1;
      tick     = 1'b0;
      position = '0;
      test_reset();
      test_priming();
      test_forward();
      test_cap();
      test_reverse_wrap();
      test_idle();
      test_tick_gating();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wheel_animator.md
WHEEL_ANIMATOR -- requirements
Module: wheel_animator

Interface
REQ-001 Parameters (name, default, meaning):
- CHANNELS, 2: number of independent wheels.
- POS_W, 32: position width per channel.
- FRAMES, 4: animation frames per wheel, at least 2.
- FRAME_W, 2: frame index width, at least clog2(FRAMES).
- STEP, 16: distance units per frame advance, at least 1.
- IDLE_TICKS, 8: ticks without motion before `moving` clears, at least 1.

REQ-002 Ports (name, direction, width, meaning):
- clk, input, 1: the only clock.
- reset, input, 1: synchronous, active-high.
- tick, input, 1: sample strobe, one clk wide, once per video frame.
- position, input, CHANNELS*POS_W: channel i at [i*POS_W +: POS_W], unsigned.
- frame, output, CHANNELS*FRAME_W: channel i at [i*FRAME_W +: FRAME_W], wheel sprite index.
- moving, output, CHANNELS: wheel considered in motion.
- reverse, output, CHANNELS: direction of last nonzero motion; 1 = decreasing position.
- mov, output, CHANNELS: legacy toggle; inverts on every tick where position changed.

REQ-003 One clock; reset is synchronous and active-high. Ports are named `clk` and `reset`.

REQ-004 All outputs are registered, with no combinational path from inputs to outputs.

Function (per channel, channels fully independent)
REQ-005 Per-channel state:
- pos_mem, POS_W bits.
- acc, clog2(STEP)+1 bits.
- idle_cnt, counts to IDLE_TICKS.
- primed flag.
- frame, moving, reverse and mov registers.

REQ-006 With tick=0, no state changes; position changes between ticks are ignored.

REQ-007 Priming tick: on a tick with primed=0:
- pos_mem <= position and primed <= 1.
- All other state holds.

REQ-008 Magnitude: on a primed tick, mag = |position - pos_mem| using an unsigned compare-then-subtract, and magc = min(mag, STEP). pos_mem <= position.

REQ-009 Still tick (mag = 0):
- acc, frame and reverse hold.
- idle_cnt increments, saturating at IDLE_TICKS.
- moving <= 0 when the incremented idle_cnt equals IDLE_TICKS.
- mov holds.

REQ-010 Motion tick (mag != 0):
- idle_cnt <= 0, moving <= 1, mov <= ~mov.
- dir = (position < pos_mem).
- reverse <= dir.

REQ-011 Direction change: on a motion tick with dir != reverse, acc is treated as 0 before accumulation.

REQ-012 Accumulation: sum = acc' + magc, where acc' is acc or 0 per REQ-011.
- If sum >= STEP: acc <= sum - STEP and frame advances one step.
- Otherwise: acc <= sum and frame holds.
- Invariant: acc < STEP always.

REQ-013 Frame advance:
- dir=0: frame+1, with FRAMES-1 wrapping to 0.
- dir=1: frame-1, with 0 wrapping to FRAMES-1.
- At most one advance per tick.

REQ-014 Latency: updated outputs are visible on the clk edge that samples tick=1, i.e. one cycle after tick is driven.

REQ-015 Position wraparound (for example 0xFFFFFFFF to 0) is treated as a large magnitude per REQ-008; no modular delta.

Reset
REQ-016 While reset=1, at each clk edge every channel is set to:
- pos_mem=0, acc=0, idle_cnt=0, primed=0.
- frame=0, moving=0, reverse=0, mov=0.

REQ-017 Reset takes priority over a simultaneous tick. The first tick after reset deasserts is a priming tick.

Verification (defaults; channel 1 held constant unless stated)
REQ-018 Priming: reset, then a tick with ch0 position=1000. Required: frame=0, moving=0, mov=0. Then a tick with position=1000. Required: outputs unchanged.

REQ-019 Forward: after priming, ch0 increments by 8 per tick. Required:
- frame sequence 0,1,1,2,2,3,3,0 on ticks 1..8.
- moving=1 and reverse=0.
- mov toggles on every tick.
- ch1 outputs stay 0.

REQ-020 Cap: from frame=0 and acc=0, a single jump of +100. Required: frame=1, acc=0 (exactly one advance).

REQ-021 Reverse and wrap: from frame=0 and acc=8 forward, ch0 decreases by 20 per tick. Required:
- reverse=1 on the first tick.
- frame 3, then 2 (acc is cleared on reversal).

REQ-022 Idle: after motion, 7 unchanged ticks. Required: moving=1. The 8th unchanged tick gives moving=0. Motion on the 8th tick instead keeps moving=1 and resets idle_cnt.

REQ-023 Reset mid-motion: assert reset on the same cycle as a motion tick. Required:
- All outputs 0 the next cycle.
- The next tick after release only primes.
